// File: rtl/move_selector_if.sv
// move_selector_if
//   Bundles the cursor/board/move signals between the game environment and
//   move_selector. The "master" side is the environment (mouse, board store,
//   move consumer); the "slave" side is move_selector itself.
//
//   environment -> selector : frame_tick, mouse_xpos, mouse_ypos, mouse_left,
//                             my_turn, side, sq_piece, legal_mask, move_ready
//   selector -> environment : hover_sq, hover_valid, src_sq, pick_place,
//                             move_valid, move_src, move_dst, cancel, state_led
interface move_selector_if #(
    parameter int BOARD_N = 8
);
    localparam int IDX_W = 2 * $clog2(BOARD_N);

    logic                       frame_tick;
    logic [11:0]                mouse_xpos;
    logic [11:0]                mouse_ypos;
    logic                       mouse_left;
    logic                       my_turn;
    logic                       side;
    logic [3:0]                 sq_piece;
    logic [BOARD_N*BOARD_N-1:0] legal_mask;
    logic                       move_ready;

    logic [IDX_W-1:0]           hover_sq;
    logic                       hover_valid;
    logic [IDX_W-1:0]           src_sq;
    logic                       pick_place;
    logic                       move_valid;
    logic [IDX_W-1:0]           move_src;
    logic [IDX_W-1:0]           move_dst;
    logic                       cancel;
    logic [3:0]                 state_led;

    modport master (
        output frame_tick, mouse_xpos, mouse_ypos, mouse_left, my_turn, side,
               sq_piece, legal_mask, move_ready,
        input  hover_sq, hover_valid, src_sq, pick_place, move_valid,
               move_src, move_dst, cancel, state_led
    );

    modport slave (
        input  frame_tick, mouse_xpos, mouse_ypos, mouse_left, my_turn, side,
               sq_piece, legal_mask, move_ready,
        output hover_sq, hover_valid, src_sq, pick_place, move_valid,
               move_src, move_dst, cancel, state_led
    );
endinterface

// File: rtl/move_selector.sv
// move_selector
//   Turns per-frame mouse samples into a pick-and-place chess move. The cursor
//   is mapped to a board square once per frame, a left-button press edge picks
//   up an own piece, and a second press edge on a legal destination commits the
//   move, which is held until the consumer accepts it.
//
//   Ports
//     clk   : system clock, rising edge
//     rst   : asynchronous, active-high reset
//     bus   : move_selector_if.slave (cursor, board, handshake, status)
//
//   Optional feature
//     MOVE_SELECTOR_TIMEOUT_EN : when defined, a pick left waiting for a
//     destination click is abandoned after TIMEOUT_FRAMES frames.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | nothing held; waiting for a press on an own piece
//   HELD   | piece picked, button still down
//   WAIT   | button released, waiting for a destination press
//   COMMIT | move presented on move_valid until move_ready
module move_selector #(
    parameter int BOARD_N        = 8,
    parameter int SQ_LOG2        = 6,
    parameter int X_ORIGIN       = 256,
    parameter int Y_ORIGIN       = 128,
    parameter int TIMEOUT_FRAMES = 600
) (
    input  logic              clk,
    input  logic              rst,
    move_selector_if.slave    bus
);
    localparam int LOG_N = $clog2(BOARD_N);
    localparam int IDX_W = 2 * LOG_N;
    localparam int SPAN  = BOARD_N << SQ_LOG2;

    localparam logic [3:0] LED_IDLE   = 4'b1000;
    localparam logic [3:0] LED_HELD   = 4'b0100;
    localparam logic [3:0] LED_WAIT   = 4'b0010;
    localparam logic [3:0] LED_COMMIT = 4'b0001;

    if (BOARD_N < 2 || BOARD_N > 16 || (BOARD_N & (BOARD_N - 1)) != 0) begin : g_bad_board_n
        $error("move_selector: BOARD_N must be a power of two in 2..16");
    end
    if (TIMEOUT_FRAMES < 1) begin : g_bad_timeout
        $error("move_selector: TIMEOUT_FRAMES must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_HELD,
        S_WAIT,
        S_COMMIT
    } state_t;

    state_t           state_q;
    logic [3:0]       state_led_q;
    logic [IDX_W-1:0] hover_sq_q;
    logic             hover_valid_q;
    logic [IDX_W-1:0] src_sq_q;
    logic             pick_place_q;
    logic             move_valid_q;
    logic [IDX_W-1:0] move_src_q;
    logic [IDX_W-1:0] move_dst_q;
    logic             cancel_q;
    logic             left_prev_q;

    // Cursor to square mapping. Offsets are taken in 13 bits so that a cursor
    // left of / above the board shows up as a set sign bit.
    logic [12:0]      x_off;
    logic [12:0]      y_off;
    logic             in_x;
    logic             in_y;
    logic [IDX_W-1:0] hover_d;

    always_comb begin
        x_off   = 13'({1'b0, bus.mouse_xpos}) - 13'(X_ORIGIN);
        y_off   = 13'({1'b0, bus.mouse_ypos}) - 13'(Y_ORIGIN);
        in_x    = !x_off[12] && ({1'b0, x_off[11:0]} < 13'(SPAN));
        in_y    = !y_off[12] && ({1'b0, y_off[11:0]} < 13'(SPAN));
        hover_d = {y_off[SQ_LOG2 +: LOG_N], x_off[SQ_LOG2 +: LOG_N]};
    end

    logic click;
    logic own_piece;
    logic click_cancel;
    logic click_legal;
    logic timeout_hit;
    logic wait_abort;

`ifdef MOVE_SELECTOR_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_FRAMES - 1);

    logic [TMR_W-1:0] timer_q;

    // Counter runs 0..TIMEOUT_FRAMES-1; the frame that would reach
    // TIMEOUT_FRAMES is the one that abandons the pick.
    assign timeout_hit = (timer_q == TMR_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        // Press edge between consecutive frame samples; a held button never
        // re-triggers.
        click        = bus.frame_tick && bus.mouse_left && !left_prev_q;
        own_piece    = bus.side ? (bus.sq_piece >= 4'd7 && bus.sq_piece <= 4'd12)
                                : (bus.sq_piece >= 4'd1 && bus.sq_piece <= 4'd6);
        click_cancel = click && (!hover_valid_q || hover_sq_q == src_sq_q);
        click_legal  = click && bus.legal_mask[hover_sq_q];
        // Losing the turn beats any click on the same frame; a legal click on
        // the last permitted frame still commits.
        wait_abort   = !bus.my_turn || click_cancel || (timeout_hit && !click_legal);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            state_led_q   <= LED_IDLE;
            hover_sq_q    <= '0;
            hover_valid_q <= 1'b0;
            src_sq_q      <= '0;
            pick_place_q  <= 1'b0;
            move_valid_q  <= 1'b0;
            move_src_q    <= '0;
            move_dst_q    <= '0;
            cancel_q      <= 1'b0;
            left_prev_q   <= 1'b0;
`ifdef MOVE_SELECTOR_TIMEOUT_EN
            timer_q       <= '0;
`endif
        end else begin
            cancel_q <= 1'b0;

            if (bus.frame_tick) begin
                left_prev_q   <= bus.mouse_left;
                hover_valid_q <= in_x && in_y;
                // Off-board samples keep the last on-board square.
                if (in_x && in_y) begin
                    hover_sq_q <= hover_d;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (click && bus.my_turn && hover_valid_q && own_piece) begin
                        state_q      <= S_HELD;
                        state_led_q  <= LED_HELD;
                        src_sq_q     <= hover_sq_q;
                        pick_place_q <= 1'b1;
                    end
                end

                S_HELD: begin
                    if (bus.frame_tick) begin
                        if (!bus.my_turn) begin
                            state_q      <= S_IDLE;
                            state_led_q  <= LED_IDLE;
                            pick_place_q <= 1'b0;
                            cancel_q     <= 1'b1;
                        end else if (!bus.mouse_left) begin
                            state_q     <= S_WAIT;
                            state_led_q <= LED_WAIT;
`ifdef MOVE_SELECTOR_TIMEOUT_EN
                            timer_q     <= '0;
`endif
                        end
                    end
                end

                S_WAIT: begin
                    if (bus.frame_tick) begin
                        if (wait_abort) begin
                            state_q      <= S_IDLE;
                            state_led_q  <= LED_IDLE;
                            pick_place_q <= 1'b0;
                            cancel_q     <= 1'b1;
                        end else if (click_legal) begin
                            state_q      <= S_COMMIT;
                            state_led_q  <= LED_COMMIT;
                            move_src_q   <= src_sq_q;
                            move_dst_q   <= hover_sq_q;
                            move_valid_q <= 1'b1;
                        end else begin
`ifdef MOVE_SELECTOR_TIMEOUT_EN
                            timer_q <= timer_q + 1'b1;
`endif
                        end
                    end
                end

                S_COMMIT: begin
                    // Handshake completes on any clock, independent of frames.
                    if (move_valid_q && bus.move_ready) begin
                        state_q      <= S_IDLE;
                        state_led_q  <= LED_IDLE;
                        move_valid_q <= 1'b0;
                        pick_place_q <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    state_led_q <= LED_IDLE;
                end
            endcase
        end
    end

    assign bus.hover_sq    = hover_sq_q;
    assign bus.hover_valid = hover_valid_q;
    assign bus.src_sq      = src_sq_q;
    assign bus.pick_place  = pick_place_q;
    assign bus.move_valid  = move_valid_q;
    assign bus.move_src    = move_src_q;
    assign bus.move_dst    = move_dst_q;
    assign bus.cancel      = cancel_q;
    assign bus.state_led   = state_led_q;
endmodule

// File: tb/tb_move_selector.sv
module tb_move_selector;
    localparam int N = 8;

    typedef struct packed {
        logic [5:0] src;
        logic [5:0] dst;
    } move_t;

    typedef struct packed {
        logic       valid;
        logic [5:0] sq;
    } hover_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    move_selector_if #(.BOARD_N(N)) bus ();

    move_selector #(
        .BOARD_N       (N),
        .SQ_LOG2       (6),
        .X_ORIGIN      (256),
        .Y_ORIGIN      (128),
        .TIMEOUT_FRAMES(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Board store: piece code at the hovered square.
    logic [3:0] board [64];
    always_comb bus.sq_piece = board[bus.hover_sq];

    int errors = 0;
    int checks = 0;
    int cancel_cnt = 0;
    int mv_cycles = 0;

    move_t  exp_q[$];
    move_t  got_q[$];
    hover_t hov_q[$];

    always @(posedge clk) begin
        if (bus.cancel) cancel_cnt <= cancel_cnt + 1;
        if (bus.move_valid) mv_cycles <= mv_cycles + 1;
        if (bus.move_valid && bus.move_ready) got_q.push_back({bus.move_src, bus.move_dst});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic set_xy(input int x, input int y);
        bus.mouse_xpos = 12'(x);
        bus.mouse_ypos = 12'(y);
    endtask

    task automatic set_cursor_sq(input int sq);
        set_xy(256 + (sq % 8) * 64 + 32, 128 + (sq / 8) * 64 + 32);
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) board[i] = 4'd0;
    endtask

    task automatic click_sq(input int sq);
        set_cursor_sq(sq);
        tick();
        bus.mouse_left = 1'b1;
        tick();
    endtask

    task automatic release_btn();
        bus.mouse_left = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        checks++;
        if (bus.state_led !== 4'b1000) begin
            errors++; $display("FAIL reset_led got=%b exp=1000", bus.state_led);
        end
        checks++;
        if ({bus.hover_valid, bus.pick_place, bus.move_valid, bus.cancel} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {bus.hover_valid, bus.pick_place, bus.move_valid, bus.cancel});
        end
        checks++;
        if ({bus.hover_sq, bus.src_sq, bus.move_src, bus.move_dst} !== 24'd0) begin
            errors++;
            $display("FAIL reset_squares got=%h exp=0",
                     {bus.hover_sq, bus.src_sq, bus.move_src, bus.move_dst});
        end
        rst = 1'b0;
        cyc(2);
    endtask

    task automatic test_hover();
        int     xs [7] = '{300, 255, 256, 767, 768, 300, 300};
        int     ys [7] = '{200, 200, 128, 639, 300, 127, 640};
        hover_t ev [7] = '{'{1'b1, 6'd8}, '{1'b0, 6'd0}, '{1'b1, 6'd0}, '{1'b1, 6'd63},
                           '{1'b0, 6'd0}, '{1'b0, 6'd0}, '{1'b0, 6'd0}};
        hover_t e;
        for (int i = 0; i < 7; i++) begin
            set_xy(xs[i], ys[i]);
            hov_q.push_back(ev[i]);
            tick();
            e = hov_q.pop_front();
            checks++;
            if (bus.hover_valid !== e.valid) begin
                errors++;
                $display("FAIL hover_valid(%0d,%0d) got=%b exp=%b", xs[i], ys[i], bus.hover_valid, e.valid);
            end
            if (e.valid) begin
                checks++;
                if (bus.hover_sq !== e.sq) begin
                    errors++;
                    $display("FAIL hover_sq(%0d,%0d) got=%0d exp=%0d", xs[i], ys[i], bus.hover_sq, e.sq);
                end
            end
        end
    endtask

    task automatic test_move();
        move_t e;
        move_t g;
        bit    seen = 0;
        clear_board();
        board[52] = 4'd1;
        bus.side = 1'b0;
        bus.my_turn = 1'b1;
        bus.move_ready = 1'b0;
        bus.legal_mask = 64'd1 << 36;
        click_sq(52);
        checks++;
        if ({bus.pick_place, bus.src_sq, bus.state_led} !== {1'b1, 6'd52, 4'b0100}) begin
            errors++;
            $display("FAIL move_pick got=%b/%0d/%b exp=1/52/0100", bus.pick_place, bus.src_sq, bus.state_led);
        end
        release_btn();
        checks++;
        if (bus.state_led !== 4'b0010) begin
            errors++; $display("FAIL move_wait_led got=%b exp=0010", bus.state_led);
        end
        exp_q.push_back({6'd52, 6'd36});
        click_sq(36);
        for (int i = 0; i < 10 && !seen; i++) begin
            if (bus.move_valid === 1'b1) seen = 1;
            else cyc(1);
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL move_valid_timeout got=0 exp=1 within 10 cycles");
        end
        e = exp_q[0];
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.move_valid, bus.move_src, bus.move_dst, bus.state_led} !== {1'b1, e.src, e.dst, 4'b0001}) begin
                errors++;
                $display("FAIL move_stable[%0d] got=%b/%0d/%0d/%b exp=1/%0d/%0d/0001", i,
                         bus.move_valid, bus.move_src, bus.move_dst, bus.state_led, e.src, e.dst);
            end
            cyc(1);
        end
        bus.move_ready = 1'b1;
        cyc(1);
        bus.move_ready = 1'b0;
        checks++;
        if ({bus.move_valid, bus.pick_place, bus.state_led} !== {2'b00, 4'b1000}) begin
            errors++;
            $display("FAIL move_done got=%b/%b/%b exp=0/0/1000", bus.move_valid, bus.pick_place, bus.state_led);
        end
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL move_sb_count got=%0d exp=1", got_q.size());
        end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++; $display("FAIL move_sb got=%0d->%0d exp=%0d->%0d", g.src, g.dst, e.src, e.dst);
            end
        end
        exp_q.delete();
        release_btn();
    endtask

    task automatic test_cancel_same();
        int c0;
        int m0;
        clear_board();
        board[52] = 4'd1;
        bus.legal_mask = 64'd1 << 36;
        click_sq(52);
        release_btn();
        c0 = cancel_cnt;
        m0 = mv_cycles;
        bus.mouse_left = 1'b1;
        tick();
        checks++;
        if ({bus.cancel, bus.pick_place, bus.state_led} !== {2'b10, 4'b1000}) begin
            errors++;
            $display("FAIL cancel_same got=%b/%b/%b exp=1/0/1000", bus.cancel, bus.pick_place, bus.state_led);
        end
        cyc(1);
        checks++;
        if (bus.cancel !== 1'b0) begin
            errors++; $display("FAIL cancel_width got=%b exp=0", bus.cancel);
        end
        cyc(2);
        checks++;
        if (cancel_cnt - c0 != 1 || mv_cycles != m0) begin
            errors++;
            $display("FAIL cancel_count got=%0d/%0d exp=1/0", cancel_cnt - c0, mv_cycles - m0);
        end
        release_btn();
    endtask

    task automatic test_illegal_then_turn();
        int c0;
        clear_board();
        board[52] = 4'd1;
        bus.legal_mask = 64'd1 << 36;
        click_sq(52);
        release_btn();
        c0 = cancel_cnt;
        click_sq(20);
        checks++;
        if ({bus.pick_place, bus.state_led, bus.move_valid} !== {1'b1, 4'b0010, 1'b0}) begin
            errors++;
            $display("FAIL illegal_stay got=%b/%b/%b exp=1/0010/0", bus.pick_place, bus.state_led, bus.move_valid);
        end
        release_btn();
        bus.my_turn = 1'b0;
        tick();
        checks++;
        if ({bus.cancel, bus.pick_place, bus.state_led} !== {2'b10, 4'b1000}) begin
            errors++;
            $display("FAIL turn_cancel got=%b/%b/%b exp=1/0/1000", bus.cancel, bus.pick_place, bus.state_led);
        end
        cyc(2);
        checks++;
        if (cancel_cnt - c0 != 1) begin
            errors++; $display("FAIL turn_cancel_count got=%0d exp=1", cancel_cnt - c0);
        end
        bus.my_turn = 1'b1;
    endtask

    task automatic test_ignored_clicks();
        clear_board();
        board[20] = 4'd7;
        bus.side = 1'b0;
        click_sq(20);
        checks++;
        if ({bus.pick_place, bus.state_led} !== {1'b0, 4'b1000}) begin
            errors++; $display("FAIL foreign_piece got=%b/%b exp=0/1000", bus.pick_place, bus.state_led);
        end
        release_btn();
        click_sq(0);
        checks++;
        if ({bus.pick_place, bus.state_led} !== {1'b0, 4'b1000}) begin
            errors++; $display("FAIL empty_square got=%b/%b exp=0/1000", bus.pick_place, bus.state_led);
        end
        release_btn();
        bus.side = 1'b1;
        click_sq(20);
        checks++;
        if ({bus.pick_place, bus.src_sq, bus.state_led} !== {1'b1, 6'd20, 4'b0100}) begin
            errors++;
            $display("FAIL side1_pick got=%b/%0d/%b exp=1/20/0100", bus.pick_place, bus.src_sq, bus.state_led);
        end
        bus.my_turn = 1'b0;
        tick();
        checks++;
        if ({bus.cancel, bus.state_led} !== {1'b1, 4'b1000}) begin
            errors++; $display("FAIL held_turn_loss got=%b/%b exp=1/1000", bus.cancel, bus.state_led);
        end
        bus.my_turn = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.pick_place, bus.state_led} !== {1'b0, 4'b1000}) begin
            errors++; $display("FAIL held_button_no_click got=%b/%b exp=0/1000", bus.pick_place, bus.state_led);
        end
        release_btn();
        bus.side = 1'b0;
    endtask

    task automatic test_timeout();
        int c0;
        clear_board();
        board[52] = 4'd1;
        bus.legal_mask = 64'd1 << 36;
        click_sq(52);
        release_btn();
        c0 = cancel_cnt;
`ifdef MOVE_SELECTOR_TIMEOUT_EN
        repeat (3) tick();
        checks++;
        if ({bus.state_led, bus.cancel} !== {4'b0010, 1'b0} || cancel_cnt != c0) begin
            errors++; $display("FAIL timeout_early got=%b/%0d exp=0010/0", bus.state_led, cancel_cnt - c0);
        end
        tick();
        checks++;
        if ({bus.cancel, bus.pick_place, bus.state_led} !== {2'b10, 4'b1000}) begin
            errors++;
            $display("FAIL timeout_cancel got=%b/%b/%b exp=1/0/1000", bus.cancel, bus.pick_place, bus.state_led);
        end
`else
        repeat (100) tick();
        cyc(1);
        checks++;
        if ({bus.state_led, bus.pick_place} !== {4'b0010, 1'b1} || cancel_cnt != c0) begin
            errors++;
            $display("FAIL wait_persist got=%b/%b/%0d exp=0010/1/0", bus.state_led, bus.pick_place, cancel_cnt - c0);
        end
        bus.mouse_left = 1'b1;
        tick();
        checks++;
        if ({bus.cancel, bus.state_led} !== {1'b1, 4'b1000}) begin
            errors++; $display("FAIL wait_exit got=%b/%b exp=1/1000", bus.cancel, bus.state_led);
        end
        release_btn();
`endif
    endtask

    task automatic test_back_to_back();
        move_t e;
        move_t g;
        bus.move_ready = 1'b1;
        clear_board();
        board[52] = 4'd1;
        bus.legal_mask = 64'd1 << 36;
        click_sq(52);
        release_btn();
        exp_q.push_back({6'd52, 6'd36});
        click_sq(36);
        release_btn();
        board[36] = board[52];
        board[52] = 4'd0;
        bus.legal_mask = 64'd1 << 28;
        click_sq(36);
        release_btn();
        exp_q.push_back({6'd36, 6'd28});
        click_sq(28);
        release_btn();
        cyc(3);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++; $display("FAIL b2b_move got=%0d->%0d exp=%0d->%0d", g.src, g.dst, e.src, e.dst);
            end
        end
        exp_q.delete();
        got_q.delete();
        bus.move_ready = 1'b0;
    endtask

    task automatic test_reset_commit();
        int c0;
        clear_board();
        board[52] = 4'd1;
        bus.legal_mask = 64'd1 << 36;
        bus.move_ready = 1'b0;
        click_sq(52);
        release_btn();
        exp_q.push_back({6'd52, 6'd36});
        click_sq(36);
        checks++;
        if ({bus.move_valid, bus.state_led} !== {1'b1, 4'b0001}) begin
            errors++; $display("FAIL rc_commit got=%b/%b exp=1/0001", bus.move_valid, bus.state_led);
        end
        c0 = cancel_cnt;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.move_valid, bus.state_led, bus.cancel, bus.pick_place} !== {1'b0, 4'b1000, 2'b00}) begin
            errors++;
            $display("FAIL rc_async got=%b/%b/%b/%b exp=0/1000/0/0",
                     bus.move_valid, bus.state_led, bus.cancel, bus.pick_place);
        end
        @(negedge clk);
        rst = 1'b0;
        // The dropped move must never be accepted.
        exp_q.delete();
        bus.move_ready = 1'b1;
        cyc(3);
        checks++;
        if (cancel_cnt != c0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL rc_dropped got=cancels %0d moves %0d exp=0/0", cancel_cnt - c0, got_q.size());
        end
        bus.move_ready = 1'b0;
        release_btn();
    endtask

    initial begin
        rst = 1'b1;
        bus.frame_tick = 1'b0;
        bus.mouse_xpos = 12'd0;
        bus.mouse_ypos = 12'd0;
        bus.mouse_left = 1'b0;
        bus.my_turn = 1'b1;
        bus.side = 1'b0;
        bus.legal_mask = '0;
        bus.move_ready = 1'b0;
        clear_board();

        test_reset();
        test_hover();
        test_move();
        test_cancel_same();
        test_illegal_then_turn();
        test_ignored_clicks();
        test_timeout();
        test_back_to_back();
        test_reset_commit();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
